// File: rtl/alu_seq_ctrl.sv
// Sequencer that collects two operands and an opcode from a switch bank
// through debounced buttons, then runs one request/response handshake
// with an external ALU and shows the result.

// Button qualifier: 2-FF synchronizer followed by a saturating
// level counter. It emits a single-cycle press when the counter reaches
// DEB_CYCLES.
module alu_seq_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync;
  logic [DW-1:0] cnt;

  // Synchronize the raw level, then count consecutive high samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= 2'b00;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (!sync[1]) begin
        cnt <= '0;
      end else if (cnt != DW'(DEB_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The press fires only on the step into saturation, so holding the
  // button cannot produce a second press.
  assign press = sync[1] && (cnt == DW'(DEB_CYCLES - 1));

endmodule

module alu_seq_ctrl #(
  parameter int N_BITS     = 6,
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_sw,
  input  logic              i_btn_enter,
  input  logic              i_btn_clear,
  output logic [N_BITS-1:0] o_alu_a,
  output logic [N_BITS-1:0] o_alu_b,
  output logic [5:0]        o_alu_op,
  output logic              o_alu_start,
  input  logic [N_BITS-1:0] i_alu_result,
  input  logic              i_alu_valid,
  output logic [N_BITS-1:0] o_led,
  output logic [2:0]        o_state,
  output logic              o_err
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state, state_next;
  logic [N_BITS-1:0] alu_a_next, alu_b_next, led_next;
  logic [5:0]        alu_op_next;
  logic              start_next, err_next;
  logic [TW-1:0]     tmo_cnt, tmo_next;
  logic              enter_press, clear_press;
  logic [5:0]        sw_op;
  logic              op_legal;

  alu_seq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clock (clock),
    .reset (reset),
    .raw   (i_btn_enter),
    .press (enter_press)
  );

  alu_seq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clock (clock),
    .reset (reset),
    .raw   (i_btn_clear),
    .press (clear_press)
  );

  // The opcode field is the low six switches, zero-extended on narrow banks.
  if (N_BITS >= 6) begin : g_op_wide
    assign sw_op = i_sw[5:0];
  end else begin : g_op_narrow
    assign sw_op = {{(6 - N_BITS){1'b0}}, i_sw};
  end

  // Decode whether the switch pattern is one of the supported opcodes.
  always_comb begin
    op_legal = 1'b0;
    case (sw_op)
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100110, 6'b000011, 6'b000010, 6'b100111: op_legal = 1'b1;
      default:                                     op_legal = 1'b0;
    endcase
  end

  // State and every registered output advance together on the clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= WAIT_A;
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_op    <= '0;
      o_alu_start <= 1'b0;
      o_led       <= '0;
      o_err       <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_next;
      o_alu_a     <= alu_a_next;
      o_alu_b     <= alu_b_next;
      o_alu_op    <= alu_op_next;
      o_alu_start <= start_next;
      o_led       <= led_next;
      o_err       <= err_next;
      tmo_cnt     <= tmo_next;
    end
  end

  // Next-state and output decisions; clear overrides everything,
  // including a simultaneous enter.
  always_comb begin
    state_next  = state;
    alu_a_next  = o_alu_a;
    alu_b_next  = o_alu_b;
    alu_op_next = o_alu_op;
    led_next    = o_led;
    err_next    = o_err;
    start_next  = 1'b0;
    tmo_next    = tmo_cnt;

    if (clear_press) begin
      state_next  = WAIT_A;
      alu_a_next  = '0;
      alu_b_next  = '0;
      alu_op_next = '0;
      led_next    = '0;
      err_next    = 1'b0;
      tmo_next    = '0;
    end else begin
      case (state)
        WAIT_A: begin
          if (enter_press) begin
            alu_a_next = i_sw;
            err_next   = 1'b0;
            state_next = WAIT_B;
          end
        end
        WAIT_B: begin
          if (enter_press) begin
            alu_b_next = i_sw;
            state_next = WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (enter_press) begin
            if (op_legal) begin
              alu_op_next = sw_op;
              start_next  = 1'b1;
              err_next    = 1'b0;
              tmo_next    = '0;
              state_next  = EXEC;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        EXEC: begin
          if (i_alu_valid) begin
            led_next   = i_alu_result;
            state_next = SHOW;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            err_next   = 1'b1;
            led_next   = '0;
            state_next = SHOW;
          end else begin
            tmo_next = tmo_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (enter_press) begin
            state_next = WAIT_A;
          end
        end
        default: begin
          state_next = WAIT_A;
        end
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed-plus-random bench for alu_seq_ctrl with a behavioural ALU.
module tb_alu_seq_ctrl;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] i_sw;
  logic       i_btn_enter, i_btn_clear;
  logic [5:0] o_alu_a, o_alu_b, o_alu_op;
  logic       o_alu_start;
  logic [5:0] i_alu_result;
  logic       i_alu_valid;
  logic [5:0] o_led;
  logic [2:0] o_state;
  logic       o_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pend = 0;
  int alu_latency = 0;
  int start_count = 0;
  int start_cyc = 0;
  int s0;
  logic [5:0] exp_result;
  logic [5:0] ra, rb, rop;
  logic [5:0] legal_ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR,
                                OP_XOR, OP_SRA, OP_SRL, OP_NOR};

  alu_seq_ctrl #(.N_BITS(6), .DEB_CYCLES(4), .TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_sw         (i_sw),
    .i_btn_enter  (i_btn_enter),
    .i_btn_clear  (i_btn_clear),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_alu_start  (o_alu_start),
    .i_alu_result (i_alu_result),
    .i_alu_valid  (i_alu_valid),
    .o_led        (o_led),
    .o_state      (o_state),
    .o_err        (o_err)
  );

  always #5 clock = ~clock;

  // Reference ALU written from the opcode table with plain arithmetic.
  function automatic logic [5:0] alu_ref(input logic [5:0] a, input logic [5:0] b,
                                         input logic [5:0] op);
    int sa, r, sh;
    sa = a[5] ? int'(a) - 64 : int'(a);
    sh = (int'(b) > 31) ? 31 : int'(b);
    case (op)
      OP_ADD:  r = int'(a) + int'(b);
      OP_SUB:  r = int'(a) - int'(b);
      OP_AND:  r = int'(a & b);
      OP_OR:   r = int'(a | b);
      OP_XOR:  r = int'(a ^ b);
      OP_SRA:  r = sa >>> sh;
      OP_SRL:  r = int'(a) >> sh;
      OP_NOR:  r = int'(~(a | b));
      default: r = 0;
    endcase
    return r[5:0];
  endfunction

  // One clock step: the ALU model answers alu_latency cycles after each start.
  task automatic tick();
    @(negedge clock);
    cyc++;
    i_alu_valid = 1'b0;
    i_alu_result = 6'($urandom);
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        i_alu_valid  = 1'b1;
        i_alu_result = exp_result;
      end
    end
    if (o_alu_start === 1'b1) begin
      start_count++;
      start_cyc = cyc;
      if (alu_latency > 0) pend = alu_latency;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // btn: 0 = enter, 1 = clear, 2 = both together.
  task automatic applyStimulus(input int btn, input logic [5:0] sw, input int hold);
    i_sw = sw;
    if (btn == 0 || btn == 2) i_btn_enter = 1'b1;
    if (btn == 1 || btn == 2) i_btn_clear = 1'b1;
    repeat (hold) tick();
    i_btn_enter = 1'b0;
    i_btn_clear = 1'b0;
    repeat (3) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_show();
    for (int k = 0; k < 40 && o_state !== 3'd4; k++) tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    i_sw = '0;
    i_btn_enter = 1'b0;
    i_btn_clear = 1'b0;
    i_alu_valid = 1'b0;
    i_alu_result = '0;
    exp_result = '0;
    repeat (3) tick();
    checkOutput("rst_state", o_state, 0);
    checkOutput("rst_led", o_led, 0);
    checkOutput("rst_err", o_err, 0);
    checkOutput("rst_a", o_alu_a, 0);
    checkOutput("rst_b", o_alu_b, 0);
    checkOutput("rst_op", o_alu_op, 0);
    checkOutput("rst_start", o_alu_start, 0);
    reset = 1'b0;
    tick();

    // Bounce: two 3-sample bursts never qualify.
    i_sw = 6'd5;
    i_btn_enter = 1'b1; repeat (3) tick();
    i_btn_enter = 1'b0; tick();
    i_btn_enter = 1'b1; repeat (3) tick();
    i_btn_enter = 1'b0; repeat (6) tick();
    checkOutput("bounce_state", o_state, 0);

    // Long hold: exactly one press.
    applyStimulus(0, 6'd5, 12);
    checkOutput("hold_state", o_state, 1);
    checkOutput("hold_a", o_alu_a, 5);

    // ADD 5 + 3.
    applyStimulus(0, 6'd3, 8);
    checkOutput("b_state", o_state, 2);
    checkOutput("b_val", o_alu_b, 3);
    alu_latency = 2;
    exp_result = alu_ref(6'd5, 6'd3, OP_ADD);
    s0 = start_count;
    applyStimulus(0, OP_ADD, 8);
    wait_show();
    checkOutput("add_led", o_led, 8);
    checkOutput("add_state", o_state, 4);
    checkOutput("add_err", o_err, 0);
    checkOutput("add_starts", start_count - s0, 1);
    checkOutput("add_op", o_alu_op, OP_ADD);

    // Enter in SHOW returns to WAIT_A without latching.
    applyStimulus(0, 6'd9, 8);
    checkOutput("show_exit_state", o_state, 0);
    checkOutput("show_exit_a", o_alu_a, 5);
    checkOutput("show_exit_led", o_led, 8);

    // Illegal opcode then NOR.
    applyStimulus(0, 6'd21, 8);
    applyStimulus(0, 6'd10, 8);
    s0 = start_count;
    applyStimulus(0, 6'b111111, 8);
    checkOutput("illegal_err", o_err, 1);
    checkOutput("illegal_state", o_state, 2);
    checkOutput("illegal_starts", start_count - s0, 0);
    checkOutput("illegal_op_hold", o_alu_op, OP_ADD);
    alu_latency = 3;
    exp_result = alu_ref(6'd21, 6'd10, OP_NOR);
    applyStimulus(0, OP_NOR, 8);
    wait_show();
    checkOutput("nor_err", o_err, 0);
    checkOutput("nor_starts", start_count - s0, 1);
    checkOutput("nor_led", o_led, 32);
    checkOutput("nor_state", o_state, 4);

    // Clear during EXEC; the late valid must be ignored.
    applyStimulus(0, 6'd0, 8);
    applyStimulus(0, 6'd7, 8);
    applyStimulus(0, 6'd9, 8);
    alu_latency = 14;
    exp_result = alu_ref(6'd7, 6'd9, OP_SUB);
    applyStimulus(0, OP_SUB, 8);
    checkOutput("clr_exec_state", o_state, 3);
    applyStimulus(1, 6'd0, 8);
    repeat (3) tick();
    checkOutput("clr_state", o_state, 0);
    checkOutput("clr_led", o_led, 0);
    checkOutput("clr_a", o_alu_a, 0);
    checkOutput("clr_b", o_alu_b, 0);
    checkOutput("clr_op", o_alu_op, 0);

    // Clear and enter together in WAIT_B.
    applyStimulus(0, 6'd11, 8);
    checkOutput("both_pre_state", o_state, 1);
    applyStimulus(2, 6'd22, 8);
    checkOutput("both_state", o_state, 0);
    checkOutput("both_a", o_alu_a, 0);
    checkOutput("both_b", o_alu_b, 0);

    // Randomized full transactions.
    for (int it = 0; it < 5; it++) begin
      ra = 6'($urandom);
      rb = 6'($urandom);
      rop = legal_ops[$urandom_range(0, 7)];
      alu_latency = $urandom_range(1, 12);
      exp_result = alu_ref(ra, rb, rop);
      s0 = start_count;
      applyStimulus(0, ra, 8);
      applyStimulus(0, rb, 8);
      applyStimulus(0, rop, 8);
      wait_show();
      checkOutput("rnd_state", o_state, 4);
      checkOutput("rnd_led", o_led, exp_result);
      checkOutput("rnd_err", o_err, 0);
      checkOutput("rnd_a", o_alu_a, ra);
      checkOutput("rnd_b", o_alu_b, rb);
      checkOutput("rnd_op", o_alu_op, rop);
      checkOutput("rnd_starts", start_count - s0, 1);
      applyStimulus(0, 6'd0, 8);
      checkOutput("rnd_back_state", o_state, 0);
    end

    // Reset mid-EXEC, enter held across reset release.
    alu_latency = 8;
    exp_result = alu_ref(6'd30, 6'd2, OP_SRL);
    applyStimulus(0, 6'd30, 8);
    applyStimulus(0, 6'd2, 8);
    applyStimulus(0, OP_SRL, 8);
    checkOutput("rexec_state", o_state, 3);
    i_sw = 6'd12;
    i_btn_enter = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("rexec_now_state", o_state, 0);
    checkOutput("rexec_now_led", o_led, 0);
    checkOutput("rexec_now_a", o_alu_a, 0);
    checkOutput("rexec_now_b", o_alu_b, 0);
    checkOutput("rexec_now_op", o_alu_op, 0);
    checkOutput("rexec_now_err", o_err, 0);
    checkOutput("rexec_now_start", o_alu_start, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) tick();
    checkOutput("rel_early_state", o_state, 0);
    checkOutput("rel_led_ignored", o_led, 0);
    tick();
    checkOutput("rel_press_state", o_state, 1);
    checkOutput("rel_press_a", o_alu_a, 12);
    i_btn_enter = 1'b0;
    repeat (3) tick();
    applyStimulus(0, 6'd7, 8);
    alu_latency = 2;
    exp_result = alu_ref(6'd12, 6'd7, OP_OR);
    applyStimulus(0, OP_OR, 8);
    wait_show();
    checkOutput("post_rst_led", o_led, 15);
    checkOutput("post_rst_state", o_state, 4);

    // Timeout with an ignored enter during EXEC.
    applyStimulus(0, 6'd0, 8);
    applyStimulus(0, 6'd9, 8);
    applyStimulus(0, 6'd4, 8);
    alu_latency = 0;
    s0 = start_count;
    applyStimulus(0, OP_XOR, 8);
    checkOutput("tmo_exec_state", o_state, 3);
    checkOutput("tmo_led_hold", o_led, 15);
    i_btn_enter = 1'b1;
    wait_until(start_cyc + 12);
    i_btn_enter = 1'b0;
    wait_until(start_cyc + 15);
    checkOutput("tmo_last_exec", o_state, 3);
    tick();
    checkOutput("tmo_state", o_state, 4);
    checkOutput("tmo_err", o_err, 1);
    checkOutput("tmo_led", o_led, 0);
    checkOutput("tmo_starts", start_count - s0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter N_BITS, default 6: width of the operands, the switch bank and the result.
REQ-002 Parameter DEB_CYCLES, default 4: consecutive high samples needed to accept a button press.
REQ-003 Parameter TIMEOUT, default 16: maximum EXEC cycles allowed for i_alu_valid to arrive.
REQ-004 Port clock, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port i_sw, input, N_BITS: switch bank, used for operand A, operand B or the opcode.
REQ-007 Port i_btn_enter, input, 1: raw asynchronous "enter" button.
REQ-008 Port i_btn_clear, input, 1: raw asynchronous "clear" button.
REQ-009 Port o_alu_a / o_alu_b, output, N_BITS each: latched operands to the ALU.
REQ-010 Port o_alu_op, output, 6: latched opcode to the ALU.
REQ-011 Port o_alu_start, output, 1: one-cycle request to the ALU.
REQ-012 Port i_alu_result, input, N_BITS; port i_alu_valid, input, 1: ALU response.
REQ-013 Port o_led, output, N_BITS: displayed result.
REQ-014 Port o_state, output, 3: FSM state code; port o_err, output, 1: error flag.

Function
REQ-015 Each button SHALL pass through a 2-FF synchronizer, then a counter that increments while the synced level is high, clears when it is low, and saturates at DEB_CYCLES.
REQ-016 The press pulse SHALL be high for exactly one cycle, when the counter goes from DEB_CYCLES-1 to DEB_CYCLES, i.e. DEB_CYCLES+2 rising edges after the raw input is first sampled high; holding the button SHALL NOT repeat the pulse.
REQ-017 The FSM SHALL have states WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, SHOW=4, and o_state SHALL equal the current state code.
REQ-018 On enter in WAIT_A: latch i_sw into o_alu_a, clear o_err, and go to WAIT_B.
REQ-019 On enter in WAIT_B: latch i_sw into o_alu_b and go to WAIT_OP.
REQ-020 Legal opcodes are 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000011 SRA, 000010 SRL and 100111 NOR.
REQ-021 On enter in WAIT_OP with a legal i_sw: latch o_alu_op, pulse o_alu_start for the one cycle after the press, clear o_err, reset the timeout counter, and go to EXEC.
REQ-022 On enter in WAIT_OP with an illegal i_sw: set o_err=1, stay in WAIT_OP, and leave o_alu_start low.
REQ-023 In EXEC, i_alu_valid=1 SHALL load i_alu_result into o_led on that edge and go to SHOW.
REQ-024 If TIMEOUT EXEC cycles elapse without i_alu_valid: set o_err=1, o_led=0, and go to SHOW.
REQ-025 Enter in EXEC SHALL be ignored.
REQ-026 In SHOW, o_led SHALL hold; enter SHALL go to WAIT_A.
REQ-027 i_alu_valid outside EXEC SHALL be ignored.
REQ-028 A clear press in any state SHALL zero o_alu_a, o_alu_b, o_alu_op, o_led and o_err, drop o_alu_start, and go to WAIT_A.
REQ-029 When clear and enter pulse in the same cycle, clear SHALL win.
REQ-030 Operands and opcode SHALL stay stable from latch until the next latch, clear or reset.

Reset
REQ-031 While reset=1: state=WAIT_A, and all outputs, debounce counters, synchronizers and the timeout counter are 0, regardless of clock.
REQ-032 Reset asserted mid-EXEC SHALL abort the operation; a later i_alu_valid SHALL NOT change o_led.
REQ-033 The first press after reset release SHALL need a full DEB_CYCLES+2 qualification.

Verification (DEB_CYCLES=4, TIMEOUT=16)
REQ-034 ADD: sw=5 + enter, sw=3 + enter, sw=100000 + enter; model returns 8 with valid 2 cycles after start -> one start pulse, o_led=8, o_state=4, o_err=0.
REQ-035 Bounce: enter high 3 cycles, low 1, high 3, low -> no press, o_state stays 0; enter high 6 cycles -> exactly one press, o_state=1.
REQ-036 Illegal opcode: sw=111111 + enter in WAIT_OP -> o_err=1, o_state=2, no start; then sw=100111 + enter -> start pulses, o_err=0.
REQ-037 Timeout: legal op, valid never asserted -> after 16 EXEC cycles o_err=1, o_led=0, o_state=4.
REQ-038 Clear in EXEC with valid arriving 3 cycles later -> o_state=0, o_led=0, valid ignored; clear and enter together in WAIT_B -> o_state=0.
REQ-039 Reset pulse mid-EXEC -> all outputs 0 immediately, o_state=0, and the full sequence then completes normally.
